// File: rtl/risc_pkg.sv
// Shared core constants: datapath width and ALU/MDU opcodes.
// Used by the ALU and the multiply/divide unit.
package risc_pkg;

   localparam int WIDTH = 32;

   localparam logic [4:0] OP_ADD = 5'b00000;
   localparam logic [4:0] OP_SUB = 5'b00001;
   localparam logic [4:0] OP_AND = 5'b00010;
   localparam logic [4:0] OP_OR  = 5'b00011;
   localparam logic [4:0] OP_XOR = 5'b00100;
   localparam logic [4:0] OP_SLL = 5'b00101;
   localparam logic [4:0] OP_SRL = 5'b00110;
   localparam logic [4:0] OP_SRA = 5'b00111;
   localparam logic [4:0] OP_SLT = 5'b01000;
   localparam logic [4:0] OP_DIV = 5'b01100;
   localparam logic [4:0] OP_MUL = 5'b01101;

endpackage

// File: rtl/div_nr_core.sv
// Unsigned non-restoring divider, one quotient bit per enabled edge.
// Exposes the post-step quotient and corrected remainder.
module div_nr_core #(
   parameter int WIDTH = risc_pkg::WIDTH
) (
   input  logic             clock,
   input  logic             clear,
   input  logic             load,
   input  logic             enable,
   input  logic [WIDTH-1:0] dividend,
   input  logic [WIDTH-1:0] divisor,
   output logic [WIDTH-1:0] quotient_next,
   output logic [WIDTH-1:0] remainder_next
);

   // two guard bits: 2*R +/- D spans one bit more than R
   logic [WIDTH+1:0] rem;
   logic [WIDTH-1:0] quo;
   logic [WIDTH-1:0] dvs;
   logic [WIDTH+1:0] shifted;
   logic [WIDTH+1:0] dext;
   logic [WIDTH+1:0] r_step;
   logic [WIDTH+1:0] r_fix;

   // one non-restoring step plus the final remainder fix-up
   always_comb begin
      dext    = {2'b00, dvs};
      shifted = {rem[WIDTH:0], quo[WIDTH-1]};
      r_step  = rem[WIDTH+1] ? shifted + dext : shifted - dext;
      r_fix   = r_step[WIDTH+1] ? r_step + dext : r_step;
      quotient_next  = {quo[WIDTH-2:0], ~r_step[WIDTH+1]};
      remainder_next = r_fix[WIDTH-1:0];
   end

   // partial remainder / quotient shift register
   always_ff @(posedge clock) begin
      if (clear) begin
         rem <= '0;
         quo <= '0;
         dvs <= '0;
      end else if (load) begin
         rem <= '0;
         quo <= dividend;
         dvs <= divisor;
      end else if (enable) begin
         rem <= r_step;
         quo <= quotient_next;
      end
   end

endmodule

// File: rtl/mul_div_unit.sv
// Iterative signed multiply (radix-2 Booth) and divide unit.
// Result is registered and presented with a one-cycle done pulse.
module mul_div_unit #(
   parameter int WIDTH = risc_pkg::WIDTH
) (
   input  logic               clock,
   input  logic               clear,
   input  logic               start,
   input  logic [4:0]         opcode,
   input  logic [WIDTH-1:0]   Ra,
   input  logic [WIDTH-1:0]   Rb,
   output logic [2*WIDTH-1:0] Rc,
   output logic               busy,
   output logic               done,
   output logic               div_by_zero
);
   import risc_pkg::*;

   localparam int CW = $clog2(WIDTH);

   typedef enum logic [1:0] {IDLE, MUL, DIV, DONE} state_t;

   state_t state, state_nxt;

   logic [CW-1:0]      cnt;
   logic [WIDTH:0]     acc;
   logic [WIDTH:0]     mcand;
   logic [WIDTH-1:0]   mq;
   logic               q_1;
   logic [WIDTH:0]     acc_sum;
   logic [WIDTH:0]     acc_nxt;
   logic [WIDTH-1:0]   mq_nxt;
   logic               q1_nxt;
   logic [2*WIDTH-1:0] rc;
   logic               dz;
   logic               neg_q;
   logic               neg_r;
   logic               accept;
   logic               acc_mul;
   logic               acc_div;
   logic               acc_dz;
   logic               last;
   logic [WIDTH-1:0]   mag_a;
   logic [WIDTH-1:0]   mag_b;
   logic [WIDTH-1:0]   q_next;
   logic [WIDTH-1:0]   r_next;
   logic [WIDTH-1:0]   div_q;
   logic [WIDTH-1:0]   div_r;

   assign accept  = (state == IDLE) && start;
   assign acc_mul = accept && (opcode == OP_MUL);
   assign acc_div = accept && (opcode == OP_DIV) && (Rb != '0);
   assign acc_dz  = accept && (opcode == OP_DIV) && (Rb == '0);
   assign last    = (cnt == CW'(WIDTH - 1));
   assign mag_a   = Ra[WIDTH-1] ? -Ra : Ra;
   assign mag_b   = Rb[WIDTH-1] ? -Rb : Rb;
   assign div_q   = neg_q ? -q_next : q_next;
   assign div_r   = neg_r ? -r_next : r_next;

   div_nr_core #(.WIDTH(WIDTH)) u_div (
      .clock          (clock),
      .clear          (clear),
      .load           (acc_div),
      .enable         (state == DIV),
      .dividend       (mag_a),
      .divisor        (mag_b),
      .quotient_next  (q_next),
      .remainder_next (r_next)
   );

   // Booth step: add/sub multiplicand, then arithmetic shift right;
   // acc carries one extra bit so -2^(W-1) operands cannot overflow
   always_comb begin
      acc_sum = acc;
      unique case ({mq[0], q_1})
         2'b01:   acc_sum = acc + mcand;
         2'b10:   acc_sum = acc - mcand;
         default: acc_sum = acc;
      endcase
      acc_nxt = {acc_sum[WIDTH], acc_sum[WIDTH:1]};
      mq_nxt  = {acc_sum[0], mq[WIDTH-1:1]};
      q1_nxt  = mq[0];
   end

   // state register
   always_ff @(posedge clock) begin
      if (clear) state <= IDLE;
      else       state <= state_nxt;
   end

   // next-state and status outputs
   always_comb begin
      state_nxt = state;
      busy      = 1'b0;
      done      = 1'b0;
      unique case (state)
         IDLE: begin
            if (acc_mul)     state_nxt = MUL;
            else if (acc_div) state_nxt = DIV;
            else if (acc_dz)  state_nxt = DONE;
         end
         MUL: begin
            busy = 1'b1;
            if (last) state_nxt = DONE;
         end
         DIV: begin
            busy = 1'b1;
            if (last) state_nxt = DONE;
         end
         DONE: begin
            done      = 1'b1;
            state_nxt = IDLE;
         end
         default: state_nxt = IDLE;
      endcase
   end

   // operand latch, iteration counter and result register
   always_ff @(posedge clock) begin
      if (clear) begin
         cnt   <= '0;
         acc   <= '0;
         mcand <= '0;
         mq    <= '0;
         q_1   <= 1'b0;
         rc    <= '0;
         dz    <= 1'b0;
         neg_q <= 1'b0;
         neg_r <= 1'b0;
      end else begin
         if (acc_mul) begin
            acc   <= '0;
            mcand <= {Ra[WIDTH-1], Ra};
            mq    <= Rb;
            q_1   <= 1'b0;
            cnt   <= '0;
            dz    <= 1'b0;
         end
         if (acc_div) begin
            neg_q <= Ra[WIDTH-1] ^ Rb[WIDTH-1];
            neg_r <= Ra[WIDTH-1];
            cnt   <= '0;
            dz    <= 1'b0;
         end
         if (acc_dz) begin
            rc  <= {Ra, {WIDTH{1'b1}}};
            dz  <= 1'b1;
            cnt <= '0;
         end
         if (state == MUL) begin
            acc <= acc_nxt;
            mq  <= mq_nxt;
            q_1 <= q1_nxt;
            cnt <= cnt + 1'b1;
            if (last) rc <= {acc_nxt[WIDTH-1:0], mq_nxt};
         end
         if (state == DIV) begin
            cnt <= cnt + 1'b1;
            if (last) rc <= {div_r, div_q};
         end
      end
   end

   assign Rc          = rc;
   assign div_by_zero = dz;

endmodule

// File: tb/tb_mul_div_unit.sv
// Directed bench for mul_div_unit with hand-computed results.
// Inputs change and outputs are sampled on the falling edge.
module tb_mul_div_unit;
   import risc_pkg::*;

   logic        clock = 1'b0;
   logic        clear;
   logic        start;
   logic [4:0]  opcode;
   logic [31:0] Ra;
   logic [31:0] Rb;
   logic [63:0] Rc;
   logic        busy;
   logic        done;
   logic        div_by_zero;

   int checks = 0;
   int errors = 0;

   mul_div_unit #(.WIDTH(32)) dut (
      .clock       (clock),
      .clear       (clear),
      .start       (start),
      .opcode      (opcode),
      .Ra          (Ra),
      .Rb          (Rb),
      .Rc          (Rc),
      .busy        (busy),
      .done        (done),
      .div_by_zero (div_by_zero)
   );

   always #5 clock = ~clock;

   task automatic chk(input string tag, input logic [63:0] got,
                      input logic [63:0] exp);
      checks++;
      if (got !== exp) begin
         errors++;
         $display("FAIL %s: got %h expected %h", tag, got, exp);
      end
   endtask

   // edges counts rising edges from the accepting one (inclusive)
   // until done is seen: 33 for a full op, 1 for divide-by-zero
   task automatic run_op(input string tag, input logic [4:0] op,
                         input logic [31:0] a, input logic [31:0] b,
                         input logic [63:0] exp_rc, input logic exp_dz,
                         input int exp_edges, input int exp_busy,
                         input bit noisy);
      int edges;
      int busy_n;
      int extra;
      @(negedge clock);
      start  = 1'b1;
      opcode = op;
      Ra     = a;
      Rb     = b;
      @(negedge clock);
      start  = 1'b0;
      Ra     = $urandom;
      Rb     = $urandom;
      edges  = 1;
      busy_n = 0;
      while (!done && edges < 40) begin
         busy_n += int'(busy);
         if (noisy && edges < 28) begin
            start  = 1'($urandom_range(0, 1));
            opcode = $urandom_range(0, 1) ? OP_MUL : OP_DIV;
            Ra     = $urandom;
            Rb     = $urandom;
         end else begin
            start = 1'b0;
         end
         @(negedge clock);
         edges++;
      end
      start = 1'b0;
      chk({tag, "_edges"}, 64'(edges), 64'(exp_edges));
      chk({tag, "_busy"}, 64'(busy_n), 64'(exp_busy));
      chk({tag, "_rc"}, Rc, exp_rc);
      chk({tag, "_dz"}, 64'(div_by_zero), 64'(exp_dz));
      @(negedge clock);
      chk({tag, "_done_low"}, 64'(done), 64'd0);
      chk({tag, "_idle"}, 64'(busy), 64'd0);
      chk({tag, "_hold"}, Rc, exp_rc);
      extra = 0;
      repeat (3) begin
         @(negedge clock);
         extra += int'(done);
      end
      chk({tag, "_extra"}, 64'(extra), 64'd0);
   endtask

   int n;
   logic [63:0] prev;

   initial begin
      clear  = 1'b1;
      start  = 1'b0;
      opcode = OP_ADD;
      Ra     = '0;
      Rb     = '0;
      repeat (2) @(negedge clock);
      chk("rst_rc", Rc, 64'd0);
      chk("rst_busy", 64'(busy), 64'd0);
      chk("rst_done", 64'(done), 64'd0);
      chk("rst_dz", 64'(div_by_zero), 64'd0);
      clear = 1'b0;

      run_op("mul_7_m3", OP_MUL, 32'd7, 32'hFFFFFFFD,
             64'hFFFFFFFF_FFFFFFEB, 1'b0, 33, 32, 1'b0);
      run_op("mul_min_min", OP_MUL, 32'h80000000, 32'h80000000,
             64'h40000000_00000000, 1'b0, 33, 32, 1'b0);
      run_op("mul_m1_1", OP_MUL, 32'hFFFFFFFF, 32'd1,
             64'hFFFFFFFF_FFFFFFFF, 1'b0, 33, 32, 1'b0);
      run_op("div_7_m2", OP_DIV, 32'd7, 32'hFFFFFFFE,
             64'h00000001_FFFFFFFD, 1'b0, 33, 32, 1'b0);
      run_op("div_m7_2", OP_DIV, 32'hFFFFFFF9, 32'd2,
             64'hFFFFFFFF_FFFFFFFD, 1'b0, 33, 32, 1'b0);
      run_op("div_min_m1", OP_DIV, 32'h80000000, 32'hFFFFFFFF,
             64'h00000000_80000000, 1'b0, 33, 32, 1'b0);
      run_op("div_100_7", OP_DIV, 32'd100, 32'd7,
             64'h00000002_0000000E, 1'b0, 33, 32, 1'b1);
      run_op("div_100_0", OP_DIV, 32'd100, 32'd0,
             64'h00000064_FFFFFFFF, 1'b1, 1, 0, 1'b0);
      chk("dz_held", 64'(div_by_zero), 64'd1);
      run_op("mul_2_3", OP_MUL, 32'd2, 32'd3,
             64'd6, 1'b0, 33, 32, 1'b1);

      // abort a multiply part way through
      @(negedge clock);
      start  = 1'b1;
      opcode = OP_MUL;
      Ra     = 32'd9;
      Rb     = 32'd9;
      @(negedge clock);
      start = 1'b0;
      repeat (10) @(negedge clock);
      clear = 1'b1;
      @(negedge clock);
      clear = 1'b0;
      chk("abort_busy", 64'(busy), 64'd0);
      chk("abort_rc", Rc, 64'd0);
      chk("abort_done", 64'(done), 64'd0);
      n = 0;
      repeat (40) begin
         @(negedge clock);
         n += int'(done) + int'(busy);
      end
      chk("abort_quiet", 64'(n), 64'd0);
      run_op("mul_5_5", OP_MUL, 32'd5, 32'd5,
             64'd25, 1'b0, 33, 32, 1'b0);

      // clear wins over a simultaneous start
      @(negedge clock);
      clear  = 1'b1;
      start  = 1'b1;
      opcode = OP_MUL;
      Ra     = 32'd3;
      Rb     = 32'd3;
      @(negedge clock);
      clear = 1'b0;
      start = 1'b0;
      chk("clr_prio_busy", 64'(busy), 64'd0);
      chk("clr_prio_rc", Rc, 64'd0);

      // non MDU opcode in IDLE is not accepted
      prev = Rc;
      @(negedge clock);
      start  = 1'b1;
      opcode = OP_ADD;
      Ra     = 32'd11;
      Rb     = 32'd13;
      @(negedge clock);
      start = 1'b0;
      n = 0;
      repeat (40) begin
         n += int'(done) + int'(busy);
         @(negedge clock);
      end
      chk("add_ignored", 64'(n), 64'd0);
      chk("add_rc", Rc, prev);

      $display("Simulation finished: %0d checks, %0d errors",
               checks, errors);
      $finish;
   end

endmodule
